dl_ram_writer: RTL
==================

# dl_ram_writer

Downstream stage of the SPI download controller: consumes its synchronised 16-bit word write strobes (`wr`, `a`, `d`, `downloading`) and commits each word to the system RAM controller through a request/acknowledge port. A small FIFO absorbs RAM latency. The block holds the CPU while a download is in flight or pending writes remain, reports completion, and tracks overflow and word count.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, 2..16
- `CNT_W`, 24: width of `words` counter
- `clk` in 1: system clock, same clock that samples the download controller's write strobe
- `reset_n` in 1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- `dl_wr` in 1: word write strobe from download controller; high for 2 consecutive `clk` cycles per word
- `dl_addr` in 25: byte address of the word, bit 0 always 0
- `dl_data` in 16: word data, low byte = even address
- `downloading` in 1: download active
- `mem_req` out 1: RAM write request
- `mem_addr` out 24: RAM word address = `dl_addr[24:1]`
- `mem_data` out 16: write data
- `mem_ack` in 1: RAM controller accept, one-cycle pulse
- `cpu_hold` out 1: stall CPU / bus masters
- `done` out 1: one-cycle completion pulse
- `overflow` out 1: sticky, a word was dropped
- `words` out `CNT_W`: words committed to RAM in current download

## Operation
- Edge detect: `wr_q` registers `dl_wr`; push when `dl_wr & ~wr_q`. A 2-cycle strobe yields exactly one push; a strobe held longer still yields one push.
- Push stores `{dl_addr[24:1], dl_data}` into FIFO.
- FIFO full and push without pop in same cycle: word dropped, `overflow` set. Full with simultaneous pop and push: push accepted.
- FSM states IDLE, REQ:
  - IDLE: FIFO non-empty -> load head into `mem_addr`/`mem_data`, pop, assert `mem_req`, go REQ.
  - REQ: `mem_req`, `mem_addr`, `mem_data` stable; on `mem_ack`=1 -> deassert `mem_req`, increment `words` (wraps at 2^CNT_W), go IDLE.
  - `mem_req` is low for at least one cycle between requests.
  - `mem_ack` in IDLE is ignored.
- `downloading` rising edge: clear `overflow` and `words`; FIFO content and in-flight request are left unaffected.
- `cpu_hold` = `downloading` | FIFO non-empty | state REQ (combinational from registers).
- `done`: one-cycle pulse in the first cycle where a download has been seen (flag set on `downloading` rise), `downloading`=0, FIFO empty and FSM IDLE; the flag then clears. No pulse without a preceding rise.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `mem_data`=0, `cpu_hold`=0 (derived), `done`=0, `overflow`=0, `words`=0, FIFO empty, FSM IDLE, `wr_q`=0.
- Reset assertion mid-request drops `mem_req` immediately (async); pending FIFO words are discarded.
- Latency: `dl_wr` rises before edge N -> entry in FIFO after edge N -> `mem_req`=1 after edge N+1 (FSM idle, FIFO previously empty).
- `mem_ack` sampled at edge M -> `mem_req`=0 and `words` incremented after edge M; next `mem_req` no earlier than after edge M+1.
- Throughput: one word per 2 cycles with zero-wait `mem_ack`; the source delivers at most one word per SPI 16-bit time, so FIFO only fills when RAM stalls.

## Configuration
- `DL_CHECKSUM_EN` defined: adds output `csum` out 16, additive sum mod 2^16 of `mem_data` for every acknowledged word, cleared on reset and on `downloading` rise, updated in the same cycle as `words`.
- Undefined: no `csum` port, no adder.

## Structure
- Package `dl_pkg`: FSM state enum (`DL_IDLE`, `DL_REQ`), `DL_AW`=24, `DL_DW`=16, FIFO entry struct `{addr, data}`.
- One sub-module `dl_fifo`: synchronous FIFO, `DEPTH` entries, ptr+1-bit full/empty, async active-low reset, registered outputs of head entry, push/pop/full/empty ports.

## Test plan
- Single word: `downloading`=1, strobe `dl_addr`=0x100000 `dl_data`=0xA55A, `mem_ack` next cycle after req -> `mem_req` 2 cycles after strobe, `mem_addr`=0x080000, `mem_data`=0xA55A, `words`=1.
- Stall/overflow: `DEPTH`=4, hold `mem_ack`=0, send 6 words -> 1 in REQ + 4 buffered, 6th dropped, `overflow`=1; release ack -> exactly 5 writes in order, `words`=5.
- Long strobe: `dl_wr` high 5 cycles -> exactly one push, one request.
- Completion: drop `downloading` with 2 words pending -> `cpu_hold` stays 1 until last ack, `done` pulses once in the next cycle, `cpu_hold`=0.
- Reset mid-request: assert `reset_n`=0 while `mem_req`=1 -> `mem_req`=0 without clock edge, `words`=0, no `done` after release.
- `DL_CHECKSUM_EN`: words 0xFFFF, 0x0002 -> `csum`=0x0001; new `downloading` rise -> `csum`=0, `overflow`=0.

Source files
------------

// File: rtl/dl_ram_writer_pkg.sv
// -----------------------------------------------------------------------------
// dl_pkg
// Shared types and widths for the download-to-RAM writer:
//   DL_AW / DL_DW : RAM word-address and data widths
//   dl_state_e    : request FSM states (DL_IDLE, DL_REQ)
//   dl_entry_t    : FIFO entry {addr, data}
// -----------------------------------------------------------------------------
package dl_pkg;

    localparam int DL_AW = 24;
    localparam int DL_DW = 16;

    typedef enum logic {
        DL_IDLE = 1'b0,
        DL_REQ  = 1'b1
    } dl_state_e;

    typedef struct packed {
        logic [DL_AW-1:0] addr;
        logic [DL_DW-1:0] data;
    } dl_entry_t;

endpackage

// File: rtl/dl_ram_writer_if.sv
// -----------------------------------------------------------------------------
// dl_ram_writer_if
// Request/acknowledge write port towards the system RAM controller.
//   mem_req  : write request, held until acknowledged
//   mem_addr : RAM word address
//   mem_data : write data
//   mem_ack  : one-cycle accept pulse from the RAM controller
// Modports: master (writer side), slave (RAM controller side).
// -----------------------------------------------------------------------------
interface dl_ram_writer_if;
    import dl_pkg::*;

    logic             mem_req;
    logic [DL_AW-1:0] mem_addr;
    logic [DL_DW-1:0] mem_data;
    logic             mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_data,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_data,
        output mem_ack
    );

endinterface

// File: rtl/dl_ram_writer_fifo.sv
// -----------------------------------------------------------------------------
// dl_fifo
// Small synchronous FIFO of dl_entry_t words that absorbs RAM latency.
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din    : write request and entry; ignored when full unless popping
//   pop          : remove head entry; ignored when empty
//   dout         : head entry, driven from the registered storage slot
//   full, empty  : status from pointers carrying one extra wrap bit
// DEPTH must be a power of two, 2..16.
// -----------------------------------------------------------------------------
module dl_fifo
    import dl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  logic      pop,
    input  dl_entry_t din,
    output dl_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_wr_en;
    logic        w_rd_en;
    dl_entry_t   w_slots [DEPTH];

    // Extra MSB distinguishes full (wrapped once) from empty.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_rd_en = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr_en = push & (~full | w_rd_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage slots need no reset: the pointers alone define validity.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        dl_entry_t r_slot;

        always_ff @(posedge clk) begin
            if (w_wr_en && (r_wr_ptr[AW-1:0] == AW'(gi))) begin
                r_slot <= din;
            end
        end

        assign w_slots[gi] = r_slot;
    end

    assign dout = w_slots[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/dl_ram_writer.sv
// -----------------------------------------------------------------------------
// dl_ram_writer
// Commits 16-bit words from the SPI download controller to system RAM.
//   clk, reset_n        : system clock, asynchronous active-low reset
//   dl_wr               : word strobe (one push per rising edge)
//   dl_addr, dl_data    : byte address (bit 0 unused) and word data
//   downloading         : download active; its rising edge starts a new session
//   mem (master)        : RAM request/acknowledge write port
//   cpu_hold            : stall CPU while downloading or writes are pending
//   done                : one-cycle pulse when a seen download has fully drained
//   overflow            : sticky, a word was dropped on a full FIFO
//   words               : words acknowledged by RAM in the current download
//   csum (DL_CHECKSUM_EN only) : 16-bit additive sum of acknowledged data
// Build option: define DL_CHECKSUM_EN to add the csum output and its adder.
// -----------------------------------------------------------------------------
module dl_ram_writer
    import dl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_wr,
    input  logic [24:0]       dl_addr,
    input  logic [15:0]       dl_data,
    input  logic              downloading,
    dl_ram_writer_if.master   mem,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  words
`ifdef DL_CHECKSUM_EN
    ,
    output logic [DL_DW-1:0]  csum
`endif
);

    logic             r_wr_q;
    logic             r_dl_q;
    logic             r_seen;
    logic             r_overflow;
    logic [CNT_W-1:0] r_words;
    dl_state_e        r_state;
    dl_state_e        w_state_next;
    logic [DL_AW-1:0] r_mem_addr;
    logic [DL_DW-1:0] r_mem_data;

    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_ack_ok;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic             w_dl_rise;
    logic             w_done;
    dl_entry_t        w_din;
    dl_entry_t        w_head;
    logic             w_unused_addr0;

    // Byte address bit 0 is always zero for word writes.
    assign w_unused_addr0 = dl_addr[0];

    assign w_push    = dl_wr & ~r_wr_q;
    assign w_dl_rise = downloading & ~r_dl_q;
    assign w_din     = {dl_addr[24:1], dl_data};
    assign w_drop    = w_push & w_full & ~w_pop;

    dl_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_din),
        .dout    (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // ---------------- request FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= DL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_ack_ok     = 1'b0;
        case (r_state)
            DL_IDLE: begin
                // An ack arriving here is stale and deliberately ignored.
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_load       = 1'b1;
                    w_state_next = DL_REQ;
                end
            end
            DL_REQ: begin
                if (mem.mem_ack) begin
                    w_ack_ok     = 1'b1;
                    w_state_next = DL_IDLE;
                end
            end
            default: w_state_next = DL_IDLE;
        endcase
    end

    // ---------------- datapath / status registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_q     <= 1'b0;
            r_dl_q     <= 1'b0;
            r_seen     <= 1'b0;
            r_overflow <= 1'b0;
            r_words    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_wr_q <= dl_wr;
            r_dl_q <= downloading;

            if (w_load) begin
                r_mem_addr <= w_head.addr;
                r_mem_data <= w_head.data;
            end

            // A word dropped in the very cycle of a new download belongs to it.
            if (w_dl_rise)   r_overflow <= w_drop;
            else if (w_drop) r_overflow <= 1'b1;

            if (w_dl_rise)     r_words <= '0;
            else if (w_ack_ok) r_words <= r_words + CNT_W'(1);

            if (w_dl_rise)   r_seen <= 1'b1;
            else if (w_done) r_seen <= 1'b0;
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [DL_DW-1:0] r_csum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csum <= '0;
        end else if (w_dl_rise) begin
            r_csum <= '0;
        end else if (w_ack_ok) begin
            r_csum <= r_csum + r_mem_data;
        end
    end

    assign csum = r_csum;
`endif

    // mem_req follows the state register so reset removes it without a clock.
    assign mem.mem_req  = (r_state == DL_REQ);
    assign mem.mem_addr = r_mem_addr;
    assign mem.mem_data = r_mem_data;

    assign w_done   = r_seen & ~downloading & w_empty & (r_state == DL_IDLE);
    assign done     = w_done;
    assign cpu_hold = downloading | ~w_empty | (r_state == DL_REQ);
    assign overflow = r_overflow;
    assign words    = r_words;

endmodule
